cpu_seq_ctrl: RTL and testbench
===============================

# cpu_seq_ctrl

Multi-cycle instruction sequencer for the 19-bit CPU. It sits between the control unit's decoded signals and the datapath. It steps each instruction through fetch, decode, execute, memory and writeback, and handshakes with instruction and data memory. It gates register and memory write enables, selects the next PC, and owns the hardware return-address stack used by Call/Ret.

## Interface
- ADDR_W, 19, PC/address width
- STACK_DEPTH, 8, return-stack entries (power of 2, ≥2)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- RegWrite, MemWrite, ResultSrc, Branch, Jump, Call, Ret  in  1 each  decoded controls; valid from DECODE onward
- Zero  in  1  ALU zero flag; valid in EXECUTE
- pc  in  ADDR_W  current PC register value
- branch_target  in  ADDR_W  computed target; valid in EXECUTE
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write strobe; qualified by dmem_req
- dmem_ack  in  1  data access complete
- ir_en  out  1  latch instruction register
- reg_we  out  1  register file write enable
- pc_en  out  1  load pc_next into PC
- pc_next  out  ADDR_W  next PC; valid when pc_en=1
- stack_cnt  out  $clog2(STACK_DEPTH)+1  valid stack entries
- fault  out  1  sticky stack fault
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, FAULT=5

## Operation
- Reset: state=FETCH, stack_cnt=0, fault=0, and every other output is 0. Stack RAM contents are not reset.
- FETCH: imem_req=1 until imem_ack is sampled high. In the ack cycle ir_en=1 and next state is DECODE.
- DECODE: one cycle, then EXECUTE.
- EXECUTE: if MemWrite or ResultSrc, go to MEM. Otherwise, if RegWrite, go to WB. Otherwise retire here.
- MEM: dmem_req=1 and dmem_we=MemWrite, held until dmem_ack. In the ack cycle: if ResultSrc and RegWrite, go to WB; otherwise retire.
- WB: reg_we=1 for one cycle, then retire.
- Retire (the final cycle of an instruction): pc_en=1 for that cycle only and next state is FETCH. pc_next priority:
  - Ret: top of stack, pop.
  - Call: branch_target, push pc+1.
  - Jump: branch_target.
  - Branch&&Zero: branch_target.
  - Otherwise: pc+1, wrapping modulo 2^ADDR_W.
- Stack:
  - Push writes entry[ptr] and increments ptr.
  - Pop returns entry[ptr-1] and decrements ptr.
  - ptr is $clog2(STACK_DEPTH) bits and wraps.
  - Push and pop take effect on the retire clock edge.
  - Ret and Call both set: Ret wins, no push.
- reg_we and dmem_we are never asserted outside WB and MEM respectively.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.

## Timing
- ALU op, no write: 3 cycles with zero-wait fetch.
- ALU op with writeback: 4 cycles.
- Store: 4 cycles plus data wait states.
- Load: 5 cycles plus wait states.
- Each wait cycle on imem_ack or dmem_ack adds exactly one cycle. Requests stay high continuously until ack.
- pc_next and pc_en are combinational from state, controls and stack. Stack and state update on the same edge.
- Reset mid-instruction: all requests and enables drop in the cycle after rst is sampled. A late ack after reset is ignored (state=FETCH restarts the request).
- rst asserted in a retire cycle: PC is not advanced by this block after reset; the stack is cleared.

## Configuration
- SEQ_STACK_GUARD_EN defined:
  - Call with stack_cnt==STACK_DEPTH, or Ret with stack_cnt==0, suppresses pc_en and the push/pop.
  - State goes to FAULT and fault=1.
  - FAULT holds, with all requests and enables 0, until rst.
- Undefined:
  - Push when full overwrites the oldest entry (circular); stack_cnt saturates at STACK_DEPTH.
  - Pop when empty returns entry[ptr-1] (stale) and wraps ptr; stack_cnt stays 0.
  - fault is tied 0 and FAULT is unreachable.

## Test plan
- ALU op, RegWrite=1, imem_ack immediate, pc=0x00010 -> states 0,1,2,4. reg_we high one cycle in WB. pc_en with pc_next=0x00011.
- Load, ResultSrc=RegWrite=1, dmem_ack after 2 waits -> dmem_req high 3 cycles, dmem_we=0, then WB. Total 7 cycles.
- Branch=1, Zero=1, branch_target=0x00200 -> retire in EXECUTE with pc_next=0x00200. Same with Zero=0 -> pc_next=pc+1. pc=0x7FFFF with Zero=0 -> pc_next=0x00000.
- Call at pc=0x00100 to 0x00400, then Ret -> stack_cnt 1 then 0; second pc_next=0x00101. Call with Ret also set -> pop only.
- Nine nested Calls with STACK_DEPTH=8:
  - Guard on: ninth Call -> state=5, fault=1, no pc_en. Only rst recovers.
  - Guard off: ninth Call succeeds, stack_cnt=8, and eight Rets return the last eight pushed addresses.
- rst pulsed while dmem_req waiting, then dmem_ack arrives -> state=FETCH, dmem_req=0, stack_cnt=0, no reg_we or pc_en generated by the late ack.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute/mem/wb sequencer with return stack; SEQ_STACK_GUARD_EN enables stack fault
module cpu_seq_ctrl #(
  parameter int ADDR_W = 19,
  parameter int STACK_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             RegWrite,
  input  logic                             MemWrite,
  input  logic                             ResultSrc,
  input  logic                             Branch,
  input  logic                             Jump,
  input  logic                             Call,
  input  logic                             Ret,
  input  logic                             Zero,
  input  logic [ADDR_W-1:0]                pc,
  input  logic [ADDR_W-1:0]                branch_target,
  output logic                             imem_req,
  input  logic                             imem_ack,
  output logic                             dmem_req,
  output logic                             dmem_we,
  input  logic                             dmem_ack,
  output logic                             ir_en,
  output logic                             reg_we,
  output logic                             pc_en,
  output logic [ADDR_W-1:0]                pc_next,
  output logic [$clog2(STACK_DEPTH):0]     stack_cnt,
  output logic                             fault,
  output logic [2:0]                       state
);
  localparam int PW = $clog2(STACK_DEPTH);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT} state_t;
  state_t state_q, state_d;
  logic run_q;
  logic fault_q, fault_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic retire, bad, push, pop;
  logic [ADDR_W-1:0] pc_inc, top;
  assign pc_inc = pc + ADDR_W'(1);
  assign top = stk_q[ptr_q - PW'(1)];
  always_comb begin
    retire = (state_q == S_EXEC && !MemWrite && !ResultSrc && !RegWrite) ||
             (state_q == S_MEM && dmem_ack && !(ResultSrc && RegWrite)) ||
             state_q == S_WB;
`ifdef SEQ_STACK_GUARD_EN
    bad = retire && ((Call && !Ret && cnt_q == (PW+1)'(STACK_DEPTH)) || (Ret && cnt_q == '0));
`else
    bad = 1'b0;
`endif
    push = retire && !bad && Call && !Ret;
    pop = retire && !bad && Ret;
    pc_next = Ret ? top : (Call || Jump || (Branch && Zero)) ? branch_target : pc_inc;
    pc_en = retire && !bad && !rst;
    state_d = bad ? S_FAULT :
              retire ? S_FETCH :
              state_q == S_FETCH ? ((run_q && imem_ack) ? S_DECODE : S_FETCH) :
              state_q == S_DECODE ? S_EXEC :
              state_q == S_EXEC ? ((MemWrite || ResultSrc) ? S_MEM : S_WB) :
              state_q == S_MEM ? (dmem_ack ? S_WB : S_MEM) : state_q;
    ptr_d = push ? ptr_q + PW'(1) : pop ? ptr_q - PW'(1) : ptr_q;
    cnt_d = push ? (cnt_q == (PW+1)'(STACK_DEPTH) ? cnt_q : cnt_q + (PW+1)'(1)) :
            pop ? (cnt_q == '0 ? cnt_q : cnt_q - (PW+1)'(1)) : cnt_q;
    fault_d = fault_q || bad;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      run_q <= 1'b0;
      fault_q <= 1'b0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= 1'b1;
      fault_q <= fault_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) stk_q[ptr_q] <= pc_inc;
  end
  assign imem_req = state_q == S_FETCH && run_q;
  assign ir_en = imem_req && imem_ack;
  assign dmem_req = state_q == S_MEM;
  assign dmem_we = dmem_req && MemWrite;
  assign reg_we = state_q == S_WB;
  assign stack_cnt = cnt_q;
  assign fault = fault_q;
  assign state = state_q;
endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: table-driven and directed checks of cpu_seq_ctrl
module tb_cpu_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic RegWrite = 0, MemWrite = 0, ResultSrc = 0, Branch = 0, Jump = 0, Call = 0, Ret = 0, Zero = 0;
  logic [18:0] pc = '0, branch_target = '0;
  logic imem_ack = 0, dmem_ack = 0;
  logic imem_req, dmem_req, dmem_we, ir_en, reg_we, pc_en, fault;
  logic [18:0] pc_next;
  logic [3:0] stack_cnt;
  logic [2:0] state;
  int n_chk = 0, n_fail = 0;
  int r_cyc, r_we, r_dreq;
  logic r_dwe, r_done;
  logic [18:0] r_pc;
  always #5 clk = ~clk;
  cpu_seq_ctrl #(.ADDR_W(19), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
    .Branch(Branch), .Jump(Jump), .Call(Call), .Ret(Ret), .Zero(Zero), .pc(pc),
    .branch_target(branch_target), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .ir_en(ir_en),
    .reg_we(reg_we), .pc_en(pc_en), .pc_next(pc_next), .stack_cnt(stack_cnt),
    .fault(fault), .state(state)
  );
  typedef struct {
    logic mw, rs, rw, br, jp, ca, rt, z;
    logic [18:0] pc, tgt;
    int iw, dw, cyc;
    logic [18:0] nx;
    int we, dreq;
    logic dwe;
    int cnt;
  } vec_t;
  vec_t tv[12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clear_ctl();
    {MemWrite, ResultSrc, RegWrite, Branch, Jump, Call, Ret, Zero} = '0;
  endtask
  task automatic run(input vec_t v);
    int iw, dw;
    {MemWrite, ResultSrc, RegWrite, Branch, Jump, Call, Ret, Zero} =
      {v.mw, v.rs, v.rw, v.br, v.jp, v.ca, v.rt, v.z};
    pc = v.pc;
    branch_target = v.tgt;
    r_cyc = 0; r_we = 0; r_dreq = 0; r_dwe = 0; r_done = 0; r_pc = '0;
    iw = 0; dw = 0;
    for (int k = 0; k < 40 && !r_done; k++) begin
      imem_ack = (state == 3'd0) && (iw >= v.iw);
      dmem_ack = (state == 3'd3) && (dw >= v.dw);
      #1;
      r_cyc++;
      if (dmem_req) r_dreq++;
      if (dmem_we) r_dwe = 1;
      if (reg_we) r_we++;
      if (pc_en) begin r_done = 1; r_pc = pc_next; end
      if (state == 3'd0) iw++;
      if (state == 3'd3) dw++;
      @(posedge clk); #1;
    end
    imem_ack = 0;
    dmem_ack = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_state", state, 0);
    chk("rst_cnt", stack_cnt, 0);
    chk("rst_fault", fault, 0);
    chk("rst_outs", {imem_req, dmem_req, dmem_we, ir_en, reg_we, pc_en}, 0);
    @(posedge clk); #1;
    chk("post_rst_imem_req", imem_req, 1);
  endtask
  initial begin
    vec_t cv;
    tv[0]  = '{0,0,1,0,0,0,0,0, 19'h00010, 19'h0,     0,0, 4, 19'h00011, 1,0,0, 0};
    tv[1]  = '{0,0,0,0,0,0,0,0, 19'h00020, 19'h0,     1,0, 4, 19'h00021, 0,0,0, 0};
    tv[2]  = '{0,1,1,0,0,0,0,0, 19'h00030, 19'h0,     0,2, 7, 19'h00031, 1,3,0, 0};
    tv[3]  = '{1,0,0,0,0,0,0,0, 19'h00031, 19'h0,     0,0, 4, 19'h00032, 0,1,1, 0};
    tv[4]  = '{0,0,0,1,0,0,0,1, 19'h00040, 19'h00200, 0,0, 3, 19'h00200, 0,0,0, 0};
    tv[5]  = '{0,0,0,1,0,0,0,0, 19'h00040, 19'h00200, 0,0, 3, 19'h00041, 0,0,0, 0};
    tv[6]  = '{0,0,0,1,0,0,0,0, 19'h7FFFF, 19'h00200, 0,0, 3, 19'h00000, 0,0,0, 0};
    tv[7]  = '{0,0,0,0,1,0,0,0, 19'h00050, 19'h01234, 0,0, 3, 19'h01234, 0,0,0, 0};
    tv[8]  = '{0,0,0,0,0,1,0,0, 19'h00100, 19'h00400, 0,0, 3, 19'h00400, 0,0,0, 1};
    tv[9]  = '{0,0,0,0,0,0,1,0, 19'h00400, 19'h0,     0,0, 3, 19'h00101, 0,0,0, 0};
    tv[10] = '{0,0,0,0,0,1,0,0, 19'h00500, 19'h00600, 0,3, 3, 19'h00600, 0,0,0, 1};
    tv[11] = '{0,0,0,0,0,1,1,0, 19'h00600, 19'h00700, 2,0, 5, 19'h00501, 0,0,0, 0};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      run(tv[i]);
      chk($sformatf("v%0d_done", i), r_done, 1);
      chk($sformatf("v%0d_cycles", i), r_cyc, tv[i].cyc);
      chk($sformatf("v%0d_pc_next", i), r_pc, tv[i].nx);
      chk($sformatf("v%0d_reg_we", i), r_we, tv[i].we);
      chk($sformatf("v%0d_dmem_req", i), r_dreq, tv[i].dreq);
      chk($sformatf("v%0d_dmem_we", i), r_dwe, tv[i].dwe);
      chk($sformatf("v%0d_stack_cnt", i), stack_cnt, tv[i].cnt);
    end
    cv = tv[8];
    for (int i = 0; i < 9; i++) begin
      cv.pc = 19'h01000 + 19'(i * 16);
      cv.tgt = 19'h02000 + 19'(i);
      run(cv);
`ifdef SEQ_STACK_GUARD_EN
      if (i == 8) begin
        chk("guard_no_pc_en", r_done, 0);
        chk("guard_state", state, 5);
        chk("guard_fault", fault, 1);
        chk("guard_outs", {imem_req, dmem_req, reg_we, pc_en, ir_en}, 0);
        chk("guard_cnt", stack_cnt, 8);
      end else begin
        chk($sformatf("call%0d_target", i), r_pc, 19'h02000 + 19'(i));
      end
`else
      chk($sformatf("call%0d_target", i), r_pc, 19'h02000 + 19'(i));
      chk($sformatf("call%0d_cnt", i), stack_cnt, (i < 8) ? i + 1 : 8);
`endif
    end
`ifdef SEQ_STACK_GUARD_EN
    do_reset();
`else
    cv = tv[9];
    for (int i = 8; i >= 1; i--) begin
      run(cv);
      chk($sformatf("ret%0d_addr", i), r_pc, 19'h01001 + 19'(i * 16));
    end
    chk("rets_cnt", stack_cnt, 0);
    chk("no_fault", fault, 0);
`endif
    run(tv[8]);
    chk("pre_rst_cnt", stack_cnt, 1);
    clear_ctl();
    ResultSrc = 1; RegWrite = 1;
    for (int k = 0; k < 10 && state != 3'd3; k++) begin
      imem_ack = (state == 3'd0);
      @(posedge clk); #1;
    end
    imem_ack = 0;
    chk("rstmem_in_mem", state, 3);
    @(posedge clk); #1;
    chk("rstmem_waiting", dmem_req, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    dmem_ack = 1;
    #1;
    chk("rstmem_state", state, 0);
    chk("rstmem_dmem_req", dmem_req, 0);
    chk("rstmem_cnt", stack_cnt, 0);
    chk("rstmem_we_pc_en", {reg_we, pc_en, imem_req}, 0);
    @(posedge clk); #1;
    chk("rstmem_late_state", state, 0);
    chk("rstmem_late_we_pc_en", {reg_we, pc_en}, 0);
    chk("rstmem_restart", imem_req, 1);
    dmem_ack = 0;
    clear_ctl();
    for (int k = 0; k < 10 && state != 3'd2; k++) begin
      imem_ack = (state == 3'd0);
      @(posedge clk); #1;
    end
    imem_ack = 0;
    chk("rstret_exec", {state, pc_en}, {3'd2, 1'b1});
    rst = 1;
    #1;
    chk("rstret_pc_en", pc_en, 0);
    @(posedge clk); #1;
    rst = 0;
    chk("rstret_state", state, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
